// File: rtl/char_disp_queue.sv
// char_disp_queue: FIFO plus hold/gap pacer that feeds characters to the 7-segment display.
// Define CHARQ_DROP_OLDEST_EN to overwrite the oldest entry on a full write instead of dropping the new one.
module char_disp_queue #(
  parameter int CW = 7,
  parameter int DEPTH = 16,
  parameter int HOLD_CYCLES = 1024,
  parameter int GAP_CYCLES = 64
) (
  input  logic                     phi,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [CW-1:0]            in_char,
  output logic                     out_valid,
  output logic [CW-1:0]            out_char,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CMAX = HOLD_CYCLES > GAP_CYCLES ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CNTW = $clog2(CMAX + 1);
  typedef enum logic [1:0] {IDLE, SHOW, GAP} state_t;
  state_t state, state_nx;
  logic [CNTW-1:0] cnt, cnt_nx;
  logic [CW-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic pop, full, lost, do_wr, do_rd;
  assign full = occupancy == (AW+1)'(DEPTH);
  assign pop = state == IDLE && occupancy != '0;
  assign lost = in_valid && full && !pop;
`ifdef CHARQ_DROP_OLDEST_EN
  assign do_wr = in_valid;
  assign do_rd = pop || lost;
`else
  assign do_wr = in_valid && !lost;
  assign do_rd = pop;
`endif
  assign out_valid = state == SHOW;
  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    case (state)
      IDLE: if (pop) begin
        state_nx = SHOW;
        cnt_nx = CNTW'(HOLD_CYCLES - 1);
      end
      SHOW: if (cnt == '0) begin
        state_nx = GAP;
        cnt_nx = CNTW'(GAP_CYCLES - 1);
      end else cnt_nx = cnt - CNTW'(1);
      GAP: if (cnt == '0) state_nx = IDLE;
      else cnt_nx = cnt - CNTW'(1);
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge phi or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      occupancy <= '0;
      overflow <= 1'b0;
      out_char <= '0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      if (do_wr != do_rd) occupancy <= do_wr ? occupancy + (AW+1)'(1) : occupancy - (AW+1)'(1);
      if (lost) overflow <= 1'b1;
      if (pop) out_char <= mem[rd_ptr];
    end
  // storage has no reset; the pointers and occupancy alone define what is valid
  always_ff @(posedge phi)
    if (do_wr) mem[wr_ptr] <= in_char;
endmodule

// File: tb/tb_char_disp_queue.sv
// tb_char_disp_queue: table, directed and random checks of char_disp_queue against a queue/timeline model.
module tb_char_disp_queue;
  localparam int DEPTH = 4;
  localparam int HOLD = 4;
  localparam int GAP = 2;
  logic phi = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic [6:0] in_char = '0;
  logic out_valid;
  logic [6:0] out_char;
  logic [2:0] occupancy;
  logic overflow;
  char_disp_queue #(.CW(7), .DEPTH(DEPTH), .HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP)) dut (
    .phi(phi), .rst_n(rst_n), .in_valid(in_valid), .in_char(in_char),
    .out_valid(out_valid), .out_char(out_char), .occupancy(occupancy), .overflow(overflow)
  );
  always #5 phi = ~phi;
  typedef struct {
    bit v;
    int c;
    bit ev;
    int ec;
    int eo;
  } vec_t;
  vec_t tbl[9];
  int checks = 0;
  int errors = 0;
  int q[$];
  bit m_ovf;
  int m_char, last_pop, next_pop, t;
  int shown[$];
  int rise_t[$];
  bit prev_v;
  int exp_list[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, t);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf = 0;
    m_char = 0;
    last_pop = -100;
    next_pop = 0;
    t = 0;
    shown.delete();
    rise_t.delete();
    prev_v = 0;
  endtask

  // one clock edge: a show starts whenever something is queued and the previous
  // character's hold+gap window (plus the idle pop cycle) has elapsed
  task automatic model_edge(input bit v, input int c);
    if (q.size() > 0 && t >= next_pop) begin
      m_char = q.pop_front();
      last_pop = t;
      next_pop = t + HOLD + GAP + 1;
    end
    if (v) begin
      if (q.size() < DEPTH) q.push_back(c);
      else begin
        m_ovf = 1;
`ifdef CHARQ_DROP_OLDEST_EN
        void'(q.pop_front());
        q.push_back(c);
`endif
      end
    end
  endtask

  task automatic step(input bit v, input int c);
    in_valid = v;
    in_char = 7'(c);
    @(posedge phi);
    t++;
    model_edge(v, c);
    #1;
    chk("occupancy", int'(occupancy), q.size());
    chk("out_valid", int'(out_valid), int'((t - last_pop) < HOLD));
    chk("out_char", int'(out_char), m_char);
    chk("overflow", int'(overflow), int'(m_ovf));
    if (out_valid && !prev_v) begin
      shown.push_back(int'(out_char));
      rise_t.push_back(t);
    end
    prev_v = out_valid;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0);
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    @(negedge phi);
    rst_n = 1'b0;
    @(negedge phi);
    rst_n = 1'b1;
    model_reset();
    chk("rst_occupancy", int'(occupancy), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_char", int'(out_char), 0);
    chk("rst_overflow", int'(overflow), 0);
  endtask

  task automatic chk_shown(input string name);
    chk({name, "_count"}, shown.size(), exp_list.size());
    for (int i = 0; i < exp_list.size(); i++)
      chk({name, "_char"}, shown.size() > i ? shown[i] : -1, exp_list[i]);
  endtask

  initial begin
    tbl[0] = '{1, 'h41, 0, 'h00, 1};
    tbl[1] = '{0, 0, 1, 'h41, 0};
    tbl[2] = '{0, 0, 1, 'h41, 0};
    tbl[3] = '{0, 0, 1, 'h41, 0};
    tbl[4] = '{0, 0, 1, 'h41, 0};
    tbl[5] = '{0, 0, 0, 'h41, 0};
    tbl[6] = '{0, 0, 0, 'h41, 0};
    tbl[7] = '{0, 0, 0, 'h41, 0};
    tbl[8] = '{0, 0, 0, 'h41, 0};
    model_reset();
    do_reset();
    for (int i = 0; i < 9; i++) begin
      step(tbl[i].v, tbl[i].c);
      chk("t1_valid", int'(out_valid), int'(tbl[i].ev));
      chk("t1_char", int'(out_char), tbl[i].ec);
      chk("t1_occ", int'(occupancy), tbl[i].eo);
    end
    chk("t1_shows", shown.size(), 1);

    do_reset();
    for (int i = 1; i <= 3; i++) step(1, i);
    idle(25);
    exp_list = '{1, 2, 3};
    chk_shown("t2");
    chk("t2_period_a", rise_t.size() > 1 ? rise_t[1] - rise_t[0] : -1, 7);
    chk("t2_period_b", rise_t.size() > 2 ? rise_t[2] - rise_t[1] : -1, 7);
    chk("t2_overflow", int'(overflow), 0);

    do_reset();
    for (int i = 0; i < 6; i++) step(1, 'h10 + i);
    idle(45);
`ifdef CHARQ_DROP_OLDEST_EN
    exp_list = '{'h10, 'h12, 'h13, 'h14, 'h15};
`else
    exp_list = '{'h10, 'h11, 'h12, 'h13, 'h14};
`endif
    chk_shown("t3");
    chk("t3_overflow", int'(overflow), 1);

    do_reset();
    for (int i = 0; i < 5; i++) step(1, 'h20 + i);
    idle(3);
    chk("t4_full", int'(occupancy), 4);
    step(1, 'h25);
    chk("t4_occ_after", int'(occupancy), 4);
    chk("t4_no_overflow", int'(overflow), 0);
    idle(40);
    exp_list = '{'h20, 'h21, 'h22, 'h23, 'h24, 'h25};
    chk_shown("t4");

    do_reset();
    for (int i = 0; i < 3; i++) step(1, 'h30 + i);
    step(0, 0);
    chk("t5_pre_valid", int'(out_valid), 1);
    chk("t5_pre_occ", int'(occupancy), 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_async_valid", int'(out_valid), 0);
    chk("t5_async_char", int'(out_char), 0);
    chk("t5_async_occ", int'(occupancy), 0);
    @(negedge phi);
    rst_n = 1'b1;
    model_reset();
    idle(20);
    chk("t5_no_emit", shown.size(), 0);

    do_reset();
    exp_list.delete();
    for (int i = 0; i < 20; i++) begin
      step(1, 'h40 + i);
      exp_list.push_back('h40 + i);
      idle(9);
    end
    idle(10);
    chk_shown("t6");
    chk("t6_overflow", int'(overflow), 0);

    do_reset();
    repeat (600) step($urandom_range(0, 3) == 0, int'($urandom_range(0, 127)));
    idle(60);
    chk("rand_drained", int'(occupancy), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/char_disp_queue.md
Name: char_disp_queue

Overview:
- Buffering and pacing stage between the cache test generator (valid strobe + 7-bit charsel) and the two-digit 7-segment display driver.
- Captures every character the generator strobes into a FIFO.
- Presents each character to the display for a fixed hold time, then a blank gap, so bursts of characters stay readable.
- Flags lost characters with a sticky overflow bit for the status LED.

Parameters:
- CW, 7, character width in bits; matches the charsel bus.
- DEPTH, 16, FIFO entries; power of 2, >= 2.
- HOLD_CYCLES, 1024, cycles each character is shown with out_valid=1; >= 1.
- GAP_CYCLES, 64, cycles with out_valid=0 between characters; >= 1.

Ports:
- phi  input  1  clock; the divided display-domain clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  single-cycle strobe; in_char is valid this cycle.
- in_char  input  CW  character code from the cache test generator.
- out_valid  output  1  high while out_char is being shown.
- out_char  output  CW  character currently presented to the display.
- occupancy  output  $clog2(DEPTH)+1  current FIFO entry count.
- overflow  output  1  sticky; a character was lost.

Behaviour:
Reset (async assert, sync deassert handled upstream):
- FIFO emptied: rd_ptr=wr_ptr=0, occupancy=0.
- out_valid=0, out_char=0, overflow=0, state=IDLE, hold counter=0.
- Reset mid-display aborts immediately; queued characters are discarded.

FIFO write:
- On in_valid, write if occupancy<DEPTH, or if a pop occurs in the same cycle.
- Otherwise drop in_char and set overflow=1.
- overflow stays set until reset.

Pacer FSM, states IDLE, SHOW, GAP:
- IDLE: if occupancy!=0, pop head. Next cycle out_char=head, out_valid=1, counter=HOLD_CYCLES-1, state=SHOW. Latency from a write into an empty queue to out_valid=1 is 2 cycles: write edge, then pop edge.
- SHOW: counter decrements each cycle. When counter==0, next cycle out_valid=0, counter=GAP_CYCLES-1, state=GAP. out_char holds its value through GAP.
- GAP: counter decrements. When counter==0, state=IDLE. IDLE may pop in the same cycle it is entered if data is pending, so steady-state period per character is HOLD_CYCLES+GAP_CYCLES+1.

Boundaries:
- Simultaneous write and pop: occupancy unchanged; pointers both advance mod DEPTH.
- Simultaneous write and pop when full: the write is accepted, not an overflow.
- Pointers wrap naturally mod DEPTH; full/empty are derived from occupancy, not from pointer compare.
- Pop only in IDLE and only when occupancy!=0. Underflow is impossible.
- in_valid with an X-free in_char is the only qualifier; in_char is ignored when in_valid=0.

Optional Feature:
CHARQ_DROP_OLDEST_EN
- Defined: a write to a full FIFO with no simultaneous pop overwrites the oldest entry.
  - wr_ptr and rd_ptr both advance.
  - occupancy stays DEPTH.
  - overflow is set.
  - The display always ends up showing the most recent DEPTH characters.
- Undefined: the newest character is dropped, as specified above.

Test Plan:
Bench parameters: DEPTH=4, HOLD_CYCLES=4, GAP_CYCLES=2.
1. Reset, then a single in_valid with in_char=7'h41.
   - out_valid rises 2 cycles later with out_char=7'h41.
   - out_valid stays high 4 cycles, low 2 cycles, then stays low.
   - occupancy returns 1→0.
2. Burst of 3 consecutive strobes 7'h01, 7'h02, 7'h03.
   - Characters shown in order.
   - Rising edges of out_valid 7 cycles apart.
   - overflow=0.
3. Burst of 6 strobes 7'h10..7'h15 while the first is being shown.
   - Without the macro: 7'h10..7'h14 shown (one popped, 4 queued); 7'h15 dropped; overflow=1.
   - With CHARQ_DROP_OLDEST_EN: 7'h10, then 7'h12..7'h15 shown; overflow=1.
4. Queue full (occupancy=4) and in_valid=1 in the IDLE pop cycle.
   - Write accepted; occupancy stays 4; overflow stays 0.
5. Assert rst_n=0 mid-SHOW with 2 entries queued.
   - out_valid=0, out_char=0, occupancy=0 immediately without waiting for a clock edge.
   - No characters emitted after release.
6. 20 strobes spaced 10 cycles apart.
   - Pointers wrap several times.
   - All 20 characters appear in order with no overflow.
